// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Optional leading-zero blanking of the hour-tens digit when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an_n,
    output logic        dp_n,
    output logic        frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    sel, sel_nx;
    logic [15:0]   snap, snap_nx;
    logic [3:0]    dp_snap, dp_snap_nx;
    logic [3:0]    digit_nx, bcd_nx, an_nx;
    logic          dp_nx, tick_nx, lzb_blank;

    // Outputs are derived from the next-state values so they register on the
    // same edge as the state they describe.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_nx   = state;
        cnt_nx     = cnt;
        sel_nx     = sel;
        snap_nx    = snap;
        dp_snap_nx = dp_snap;
        tick_nx    = 1'b0;

        if (!en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            sel_nx   = '0;
        end else if (state == IDLE) begin
            state_nx   = BLANK;
            cnt_nx     = '0;
            sel_nx     = '0;
            snap_nx    = digits_in;
            dp_snap_nx = dp_in;
            tick_nx    = 1'b1;
        end else if (cnt == CNT_LAST) begin
            state_nx = BLANK;
            cnt_nx   = '0;
            sel_nx   = sel + 2'd1;
            if (sel == 2'd3) begin
                snap_nx    = digits_in;
                dp_snap_nx = dp_in;
                tick_nx    = 1'b1;
            end
        end else begin
            cnt_nx = cnt + 1'b1;
            if (state == BLANK && cnt == BLANK_LAST)
                state_nx = SHOW;
        end

        digit_nx = snap_nx[sel_nx*4 +: 4];

`ifdef SEG_SCAN_LZB_EN
        lzb_blank = (sel_nx == 2'd3) && (digit_nx == 4'd0);
`else
        lzb_blank = 1'b0;
`endif

        bcd_nx = (state_nx == IDLE) ? 4'd0 : digit_nx;
        an_nx  = 4'b1111;
        dp_nx  = 1'b1;
        // Invalid BCD would light every segment through the decoder, so keep it dark.
        if (state_nx == SHOW && digit_nx <= 4'd9) begin
            dp_nx = ~dp_snap_nx[sel_nx];
            if (!lzb_blank)
                an_nx = ~(4'b0001 << sel_nx);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= '0;
            snap       <= '0;
            dp_snap    <= '0;
            bcd_out    <= '0;
            an_n       <= 4'b1111;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            sel        <= sel_nx;
            snap       <= snap_nx;
            dp_snap    <= dp_snap_nx;
            bcd_out    <= bcd_nx;
            an_n       <= an_nx;
            dp_n       <= dp_nx;
            frame_tick <= tick_nx;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with REFRESH_DIV=8, BLANK_CYCLES=2.
// Output vectors are packed as {an_n, bcd_out, dp_n, frame_tick}.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  bcd_out;
    logic [3:0]  an_n;
    logic        dp_n;
    logic        frame_tick;

    int vectors     = 0;
    int miscompares = 0;

`ifdef SEG_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [9:0] DARK = {4'b1111, 4'd0, 1'b1, 1'b0};

    seg_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .dp_in(dp_in),
        .bcd_out(bcd_out), .an_n(an_n), .dp_n(dp_n), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Expected outputs at cycle pos (0..31) of a frame showing digits d with dp request dp:
    // 8-cycle slots, first 2 cycles dark, then digit lit unless invalid or blanked.
    function automatic logic [9:0] exp_vec(input int pos, input logic [15:0] d, input logic [3:0] dp);
        int         slot;
        logic [3:0] val, an;
        logic       dpn;
        slot = pos / 8;
        val  = d[slot*4 +: 4];
        an   = 4'b1111;
        dpn  = 1'b1;
        if ((pos % 8) >= 2 && val <= 4'd9) begin
            dpn = ~dp[slot];
            if (!(LZB && slot == 3 && val == 4'd0))
                an = ~(4'b0001 << slot);
        end
        return {an, val, dpn, pos == 0};
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; digits_in = 16'h0; dp_in = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({an_n, bcd_out, dp_n, frame_tick} !== DARK) begin
            miscompares++;
            $display("FAIL reset got=%b required=%b", {an_n, bcd_out, dp_n, frame_tick}, DARK);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({an_n, bcd_out, dp_n, frame_tick} !== DARK) begin
            miscompares++;
            $display("FAIL idle_dark got=%b required=%b", {an_n, bcd_out, dp_n, frame_tick}, DARK);
        end
    endtask

    task automatic test_scan();
        digits_in = 16'h1234; dp_in = 4'b0100; en = 1'b1;
        for (int pos = 0; pos < 32; pos++) begin
            @(posedge clk); #1;
            vectors++;
            if ({an_n, bcd_out, dp_n, frame_tick} !== exp_vec(pos, 16'h1234, 4'b0100)) begin
                miscompares++;
                $display("FAIL scan pos=%0d got=%b required=%b", pos,
                         {an_n, bcd_out, dp_n, frame_tick}, exp_vec(pos, 16'h1234, 4'b0100));
            end
        end
    endtask

    task automatic test_snapshot();
        for (int pos = 0; pos < 32; pos++) begin
            @(posedge clk); #1;
            vectors++;
            if ({an_n, bcd_out, dp_n, frame_tick} !== exp_vec(pos, 16'h1234, 4'b0100)) begin
                miscompares++;
                $display("FAIL snapshot_hold pos=%0d got=%b required=%b", pos,
                         {an_n, bcd_out, dp_n, frame_tick}, exp_vec(pos, 16'h1234, 4'b0100));
            end
            if (pos == 10) digits_in = 16'h5678;
        end
        for (int pos = 0; pos < 32; pos++) begin
            @(posedge clk); #1;
            vectors++;
            if ({an_n, bcd_out, dp_n, frame_tick} !== exp_vec(pos, 16'h5678, 4'b0100)) begin
                miscompares++;
                $display("FAIL snapshot_new pos=%0d got=%b required=%b", pos,
                         {an_n, bcd_out, dp_n, frame_tick}, exp_vec(pos, 16'h5678, 4'b0100));
            end
        end
    endtask

    task automatic test_invalid_bcd();
        digits_in = 16'h00A0; dp_in = 4'b0010;
        for (int pos = 0; pos < 32; pos++) begin
            @(posedge clk); #1;
            vectors++;
            if ({an_n, bcd_out, dp_n, frame_tick} !== exp_vec(pos, 16'h00A0, 4'b0010)) begin
                miscompares++;
                $display("FAIL invalid_bcd pos=%0d got=%b required=%b", pos,
                         {an_n, bcd_out, dp_n, frame_tick}, exp_vec(pos, 16'h00A0, 4'b0010));
            end
        end
    endtask

    task automatic test_en_drop();
        digits_in = 16'h1234; dp_in = 4'b0100;
        for (int pos = 0; pos < 20; pos++) begin
            @(posedge clk); #1;
            vectors++;
            if ({an_n, bcd_out, dp_n, frame_tick} !== exp_vec(pos, 16'h1234, 4'b0100)) begin
                miscompares++;
                $display("FAIL pre_drop pos=%0d got=%b required=%b", pos,
                         {an_n, bcd_out, dp_n, frame_tick}, exp_vec(pos, 16'h1234, 4'b0100));
            end
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({an_n, bcd_out, dp_n, frame_tick} !== DARK) begin
                miscompares++;
                $display("FAIL en_drop cyc=%0d got=%b required=%b", i, {an_n, bcd_out, dp_n, frame_tick}, DARK);
            end
        end
        en = 1'b1;
        for (int pos = 0; pos < 32; pos++) begin
            @(posedge clk); #1;
            vectors++;
            if ({an_n, bcd_out, dp_n, frame_tick} !== exp_vec(pos, 16'h1234, 4'b0100)) begin
                miscompares++;
                $display("FAIL restart pos=%0d got=%b required=%b", pos,
                         {an_n, bcd_out, dp_n, frame_tick}, exp_vec(pos, 16'h1234, 4'b0100));
            end
        end
    endtask

    task automatic test_leading_zero();
        en = 1'b0;
        @(posedge clk); #1;
        digits_in = 16'h0930; dp_in = 4'b1000; en = 1'b1;
        for (int pos = 0; pos < 32; pos++) begin
            @(posedge clk); #1;
            vectors++;
            if ({an_n, bcd_out, dp_n, frame_tick} !== exp_vec(pos, 16'h0930, 4'b1000)) begin
                miscompares++;
                $display("FAIL leading_zero pos=%0d got=%b required=%b", pos,
                         {an_n, bcd_out, dp_n, frame_tick}, exp_vec(pos, 16'h0930, 4'b1000));
            end
        end
    endtask

    task automatic test_async_reset();
        for (int pos = 0; pos < 5; pos++) begin
            @(posedge clk); #1;
            vectors++;
            if ({an_n, bcd_out, dp_n, frame_tick} !== exp_vec(pos, 16'h0930, 4'b1000)) begin
                miscompares++;
                $display("FAIL pre_reset pos=%0d got=%b required=%b", pos,
                         {an_n, bcd_out, dp_n, frame_tick}, exp_vec(pos, 16'h0930, 4'b1000));
            end
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({an_n, bcd_out, dp_n, frame_tick} !== DARK) begin
            miscompares++;
            $display("FAIL async_reset got=%b required=%b", {an_n, bcd_out, dp_n, frame_tick}, DARK);
        end
        #1 rst = 1'b0;
        for (int pos = 0; pos < 32; pos++) begin
            @(posedge clk); #1;
            vectors++;
            if ({an_n, bcd_out, dp_n, frame_tick} !== exp_vec(pos, 16'h0930, 4'b1000)) begin
                miscompares++;
                $display("FAIL post_reset pos=%0d got=%b required=%b", pos,
                         {an_n, bcd_out, dp_n, frame_tick}, exp_vec(pos, 16'h0930, 4'b1000));
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_invalid_bcd();
        test_en_drop();
        test_leading_zero();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit common-anode 7-segment display on the digital clock.
- Shares one BCD-to-7-segment decoder between four BCD digits: selects the digit, drives the decoder's 4-bit input, and drives active-low anodes and the decimal point.
- Sits between the timekeeping counters (HH:MM BCD) and the decoder/pins.
- Inserts a per-slot blanking gap to suppress ghosting, and snapshots inputs once per frame to avoid tearing.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz/digit at 100 MHz); legal range >= 4.
- BLANK_CYCLES, 16, cycles at start of each slot with all anodes off; legal range 1..REFRESH_DIV-2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; 0 = display dark.
- digits_in  in  16  four BCD digits; [3:0]=digit0 (min units) .. [15:12]=digit3 (hour tens).
- dp_in  in  4  decimal point request per digit, 1=lit; bit i -> digit i.
- bcd_out  out  4  BCD value to the shared decoder.
- an_n  out  4  anode enables, active-low; bit i -> digit i.
- dp_n  out  1  decimal point cathode, active-low.
- frame_tick  out  1  one-cycle pulse at the start of each frame (sel wraps to 0).

Behaviour:
- Clocking/reset: one clock. Reset is asynchronous and active-high. All outputs registered.
- Reset values: state=IDLE, cnt=0, sel=0, snap=0, dp_snap=0, bcd_out=0, an_n=4'b1111, dp_n=1, frame_tick=0.
- State machine: IDLE, BLANK, SHOW.
  - IDLE: an_n=1111, dp_n=1, cnt=0, sel=0. If en=1, next edge -> BLANK with sel=0, cnt=0, snap<=digits_in, dp_snap<=dp_in, frame_tick=1.
  - BLANK: an_n=1111, dp_n=1, bcd_out=snap[sel]. cnt increments. When cnt==BLANK_CYCLES-1 -> SHOW.
  - SHOW: an_n=~(1<<sel), dp_n=~dp_snap[sel], bcd_out=snap[sel]. cnt increments.
- Slot end: when cnt==REFRESH_DIV-1, cnt<=0, sel<=(sel+1) mod 4, state<=BLANK. Slot length is exactly REFRESH_DIV cycles: BLANK_CYCLES dark, REFRESH_DIV-BLANK_CYCLES lit.
- Frame: when sel wraps 3->0, snap/dp_snap reload from inputs on the same edge and frame_tick=1 for that one cycle. Input changes mid-frame are not visible until the next frame.
- Invalid BCD: if snap[sel]>9, the anode for that slot stays off for the whole SHOW phase (decoder default would light all segments). dp_n=1 in that slot. bcd_out still carries the value.
- en deassert: any state -> IDLE on the next edge; outputs dark on that edge. An en glitch restarts the frame from digit 0.
- Counter widths: cnt is $clog2(REFRESH_DIV) bits; sel is 2 bits, wraps naturally.
- No output is combinationally dependent on inputs.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN.
- Defined: leading-zero blanking for hour tens. If snap[3]==0, the digit3 anode stays off during SHOW. dp_n follows dp_snap[3] normally.
- Undefined: digit3 shown as 0 like any other digit.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2 unless stated):
- Reset mid-SHOW, rst pulsed asynchronously between edges -> an_n=1111, bcd_out=0, dp_n=1, frame_tick=0 immediately, without waiting for a clk edge.
- en=1, digits_in=16'h1234, dp_in=4'b0100 -> per slot 2 cycles an_n=1111 then 6 cycles an_n=1110/1101/1011/0111 with bcd_out=4/3/2/1. dp_n=0 only in the digit2 SHOW phase. frame_tick every 32 cycles.
- Change digits_in to 16'h5678 during digit1 slot -> remainder of frame still shows 1234; next frame shows 8,7,6,5.
- digits_in=16'h00A0 -> digit1 slot an_n=1111 throughout; other slots lit with bcd_out=0.
- en dropped during digit2 SHOW -> next edge an_n=1111, state IDLE. Re-assert -> first lit anode is 1110 after 2 blank cycles.
- SEG_SCAN_LZB_EN defined, digits_in=16'h0930 -> digit3 slot dark. Undefined -> digit3 lit with bcd_out=0.
